req_arbiter_8: RTL
==================

Name: req_arbiter_8

Overview:
- 8-requester bus arbiter that shares one resource among requesters `req[7:0]`.
- Supports two priority modes:
  - fixed priority, where bit 7 is highest, the same ordering as the 8-to-3 priority encoder;
  - round-robin.
- Grants are registered and held while the owner keeps requesting.
- A hold-timeout counter forces release so that no requester can starve the others.
- Sits between request sources and a shared datapath; `gnt` drives the datapath's select mux.

Parameters:
- MAX_HOLD, 16, maximum consecutive cycles one grant may be held. Legal range 1..255.
- CNT_W, 8, width of the hold counter. Must satisfy 2^CNT_W > MAX_HOLD.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- req  input  8  request lines; bit i is requester i's request.
- rr_en  input  1  1 selects round-robin mode, 0 selects fixed priority. Sampled only in IDLE.
- gnt  output  8  one-hot grant; all zeros when no grant is active.
- gnt_id  output  3  binary index of the granted requester. Holds 0 when `gnt_valid`=0.
- gnt_valid  output  1  high while a grant is active.
- timeout  output  1  single-cycle pulse when a grant is force-released by MAX_HOLD.

Behaviour:
- Reset (`rst`=1 at a clock edge), taking effect on that edge regardless of state, including mid-grant:
  - state goes to IDLE;
  - `gnt`=0, `gnt_id`=0, `gnt_valid`=0, `timeout`=0;
  - hold counter = 0;
  - RR pointer `last`=0.
- State machine, two states:
  - IDLE:
    - If `req`≠0 at the edge, latch the winner: `gnt`=onehot(w), `gnt_id`=w, `gnt_valid`=1, counter=1, `last`=w. Go to GRANT.
    - Latency is 1 cycle, from the `req` sampled at edge k to `gnt` visible after edge k.
    - If `req`=0, remain in IDLE with outputs zero.
  - GRANT:
    - Keep the grant if `req[gnt_id]`=1 and counter<MAX_HOLD; counter increments.
    - Release if `req[gnt_id]`=0 (normal release) or counter==MAX_HOLD (timeout). Next cycle: `gnt`=0, `gnt_id`=0, `gnt_valid`=0, counter=0, state=IDLE.
    - On a timeout release, `timeout`=1 for exactly that one cycle.
    - A release requires one IDLE cycle, so there is a minimum 1-cycle gap between consecutive grants.
- Winner selection in IDLE:
  - Fixed mode (`rr_en`=0): the highest set index wins; search order 7,6,…,0. `last` is still updated.
  - RR mode (`rr_en`=1): search order is last-1, last-2, …, 0, 7, …, last, wrapping modulo 8. The previous winner therefore becomes lowest priority. With `last`=0 after reset, the order is 7..0, identical to fixed mode.
  - Timeout victim: the requester released by timeout is excluded from the immediately following IDLE arbitration, in both modes. If it is the sole requester, that IDLE cycle grants nothing. It is eligible again from the next cycle.
- Changes to `req` bits other than the owner's have no effect during GRANT.
- Changes to `rr_en` during GRANT take effect at the next IDLE.
- MAX_HOLD=1: every grant lasts exactly 1 cycle, and every release while the owner still requests is a timeout.
- Counter width: compares use CNT_W bits and must not wrap. Parameter legality is the integrator's responsibility; no runtime check.
- Invariants:
  - `gnt` is always zero or one-hot.
  - `gnt_valid` == |`gnt`.
  - `gnt_id` == encode(`gnt`).
  - `timeout` is never high while `gnt_valid`=1.

Test Plan:
- Reset and fixed priority: with `rst`=1, `req`=8'hFF → all outputs 0. Release `rst` with `rr_en`=0, `req`=8'b0010_0110 → after 1 edge `gnt`=8'b0010_0000, `gnt_id`=5, `gnt_valid`=1.
- Hold and release: `req[5]` held for 4 cycles, then dropped → `gnt` stable for those cycles. Next cycle `gnt_valid`=0 and `timeout`=0. Following cycle grants bit 2 (`req`=8'b0000_0110).
- Round-robin rotation: `rr_en`=1, `req`=8'hFF, each owner drops its request after 1 grant cycle then reasserts → grant sequence 7,6,5,4,3,2,1,0,7, separated by 1-cycle gaps.
- Timeout: MAX_HOLD=16, `req`=8'b1000_0001 held constant, fixed mode:
  - requester 7 is granted for exactly 16 cycles;
  - `timeout` pulses for 1 cycle with `gnt`=0;
  - next grant goes to 0 (7 excluded);
  - after 0 times out, 7 wins again.
- Sole-requester timeout: `req`=8'b0000_1000 held constant → 16 cycles granted, IDLE with `timeout`=1, a further IDLE cycle with no grant, then requester 3 regranted.
- Reset mid-grant: assert `rst` for 1 cycle during GRANT at counter=7 → next cycle all outputs 0. The first arbitration after reset with `rr_en`=1 uses search order 7..0.

Source files
------------

// File: rtl/req_arbiter_8.sv
// req_arbiter_8: 8-requester arbiter with fixed/round-robin priority and hold timeout.
// Rev 1.0 - initial release.
`default_nettype none

module req_arbiter_8 #(
  parameter int MAX_HOLD = 16,
  parameter int CNT_W    = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] req,
  input  logic       rr_en,
  output logic [7:0] gnt,
  output logic [2:0] gnt_id,
  output logic       gnt_valid,
  output logic       timeout
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] HOLD_LIMIT = CNT_W'(MAX_HOLD);

  state_t           state;
  logic [CNT_W-1:0] hold_cnt;
  logic [2:0]       last;
  logic [7:0]       excluded;

  logic [7:0] eligible;
  logic [2:0] base;
  logic [2:0] idx;
  logic [2:0] winner;
  logic       found;

  // Scan positions relative to base; the highest relative position wins, so
  // with base=last the search order is last-1, last-2, ..., last.
  always_comb begin
    eligible = req & ~excluded;
    base     = rr_en ? last : 3'd0;
    winner   = 3'd0;
    found    = 1'b0;
    idx      = 3'd0;
    for (int j = 0; j < 8; j++) begin
      idx = 3'(j) + base;
      if (eligible[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      gnt       <= 8'd0;
      gnt_id    <= 3'd0;
      gnt_valid <= 1'b0;
      timeout   <= 1'b0;
      hold_cnt  <= '0;
      last      <= 3'd0;
      excluded  <= 8'd0;
    end else begin
      case (state)
        IDLE: begin
          timeout  <= 1'b0;
          excluded <= 8'd0;
          if (found) begin
            gnt       <= 8'(1) << winner;
            gnt_id    <= winner;
            gnt_valid <= 1'b1;
            hold_cnt  <= CNT_W'(1);
            last      <= winner;
            state     <= GRANT;
          end
        end
        GRANT: begin
          if (req[gnt_id] && (hold_cnt < HOLD_LIMIT)) begin
            hold_cnt <= hold_cnt + CNT_W'(1);
          end else begin
            // A still-requesting owner was cut off: flag it and bar it from the next arbitration.
            if (req[gnt_id]) begin
              timeout  <= 1'b1;
              excluded <= gnt;
            end
            gnt       <= 8'd0;
            gnt_id    <= 3'd0;
            gnt_valid <= 1'b0;
            hold_cnt  <= '0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire
